// File: rtl/ercm_pkg.sv
`default_nettype none
// ============================================================================
// ercm_pkg - shared helpers and default-width types for the ERCM multiplier.
// Rev 1.0
// ============================================================================
package ercm_pkg;

  function automatic int ercm_clog2(input int value);
    int r;
    r = 0;
    while ((32'd1 << r) < value) r = r + 1;
    return r;
  endfunction

  localparam int ERCM_WIDTH = 8;
  localparam int ERCM_KW    = ercm_clog2(2*ERCM_WIDTH+1);

  typedef logic [ERCM_KW-1:0]      ercm_k_t;
  typedef logic [2*ERCM_WIDTH-1:0] ercm_prod_t;

endpackage
`default_nettype wire

// File: rtl/ercm_col_compress.sv
`default_nettype none
// ============================================================================
// ercm_col_compress - OR-compresses columns below K, reduces the rest to two
// carry-save rows. Rev 1.0
// ============================================================================
module ercm_col_compress
  import ercm_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int KW = ercm_clog2(2*WIDTH+1),
  localparam int PW = 2*WIDTH
)(
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [KW-1:0]    i_k,
  output logic [PW-1:0]    o_low,
  output logic [PW-1:0]    o_row0,
  output logic [PW-1:0]    o_row1
);

  logic [PW-1:0] w_lo_mask;
  logic [PW-1:0] w_pp [WIDTH];
  logic [PW-1:0] w_hi [WIDTH];
  logic [PW-1:0] w_or [WIDTH];
  logic [PW-1:0] w_s  [1:WIDTH-1];
  logic [PW-1:0] w_c  [1:WIDTH-1];

  for (genvar gc = 0; gc < PW; gc++) begin : g_mask
    assign w_lo_mask[gc] = (KW'(gc) < i_k);
  end

  // Row i holds pp[i][*] aligned to its columns; OR over rows = OR over a column.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_row
    assign w_pp[gi] = {{WIDTH{1'b0}}, i_a & {WIDTH{i_b[gi]}}} << gi;
    assign w_hi[gi] = w_pp[gi] & ~w_lo_mask;
    if (gi == 0) begin : g_first
      assign w_or[gi] = w_pp[gi];
    end else begin : g_rest
      assign w_or[gi] = w_or[gi-1] | w_pp[gi];
    end
  end

  assign o_low = w_or[WIDTH-1] & w_lo_mask;

  // High rows contain only bits at or above K, so carries can never reach below K.
  assign w_s[1] = w_hi[0];
  assign w_c[1] = w_hi[1];
  for (genvar gr = 2; gr < WIDTH; gr++) begin : g_csa
    assign w_s[gr] = w_s[gr-1] ^ w_c[gr-1] ^ w_hi[gr];
    assign w_c[gr] = ((w_s[gr-1] & w_c[gr-1]) | (w_s[gr-1] & w_hi[gr]) |
                      (w_c[gr-1] & w_hi[gr])) << 1;
  end

  assign o_row0 = w_s[WIDTH-1];
  assign o_row1 = w_c[WIDTH-1];

endmodule
`default_nettype wire

// File: rtl/ercm_mult_pipe.sv
`default_nettype none
// ============================================================================
// ercm_mult_pipe - 3-stage valid/ready approximate multiplier, runtime K.
// Optional error statistics via ERCM_ERR_STAT_EN. Rev 1.0
// ============================================================================
module ercm_mult_pipe
  import ercm_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int K_RST = 4,
`ifdef ERCM_ERR_STAT_EN
  parameter int CNT_W = 16,
`endif
  localparam int KW = ercm_clog2(2*WIDTH+1),
  localparam int PW = 2*WIDTH
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [WIDTH-1:0] dat_in_a,
  input  logic [WIDTH-1:0] dat_in_b,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [PW-1:0]    dat_o,
  input  logic             cfg_we,
  input  logic [KW-1:0]    cfg_k,
  output logic [KW-1:0]    k_o
`ifdef ERCM_ERR_STAT_EN
  ,
  input  logic             err_clr,
  output logic [CNT_W-1:0] err_cnt
`endif
);

  logic             r_v1, r_v2, r_v3;
  logic [WIDTH-1:0] r_a1, r_b1;
  logic [KW-1:0]    r_k1, r_k;
  logic [PW-1:0]    r_low2, r_s2, r_c2, r_dat3;
  logic [PW-1:0]    w_low, w_row0, w_row1, w_sum;
  logic [KW-1:0]    w_k_sat;
  logic             w_ld2, w_ld3, w_adv1, w_adv2, w_in_rdy;

  assign w_ld3    = !r_v3 || out_rdy;
  assign w_adv2   = r_v2 && w_ld3;
  assign w_ld2    = !r_v2 || w_adv2;
  assign w_adv1   = r_v1 && w_ld2;
  assign w_in_rdy = !r_v1 || w_adv1;

  assign w_k_sat = (cfg_k > KW'(PW)) ? KW'(PW) : cfg_k;

  ercm_col_compress #(.WIDTH(WIDTH)) u_compress (
    .i_a    (r_a1),
    .i_b    (r_b1),
    .i_k    (r_k1),
    .o_low  (w_low),
    .o_row0 (w_row0),
    .o_row1 (w_row1)
  );

  assign w_sum = r_s2 + r_c2 + r_low2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1   <= 1'b0;
      r_v2   <= 1'b0;
      r_v3   <= 1'b0;
      r_a1   <= '0;
      r_b1   <= '0;
      r_k1   <= '0;
      r_low2 <= '0;
      r_s2   <= '0;
      r_c2   <= '0;
      r_dat3 <= '0;
      r_k    <= KW'(K_RST);
    end else begin
      if (w_in_rdy) r_v1 <= in_vld;
      // K is captured with the operands so later writes never touch this op.
      if (w_in_rdy && in_vld) begin
        r_a1 <= dat_in_a;
        r_b1 <= dat_in_b;
        r_k1 <= r_k;
      end
      if (w_ld2) r_v2 <= r_v1;
      if (w_adv1) begin
        r_low2 <= w_low;
        r_s2   <= w_row0;
        r_c2   <= w_row1;
      end
      if (w_ld3) r_v3 <= r_v2;
      if (w_adv2) r_dat3 <= w_sum;
      if (cfg_we) r_k <= w_k_sat;
    end
  end

  assign in_rdy  = w_in_rdy;
  assign out_vld = r_v3;
  assign dat_o   = r_dat3;
  assign k_o     = r_k;

`ifdef ERCM_ERR_STAT_EN
  logic [WIDTH-1:0] r_a2, r_b2;
  logic             r_inex3;
  logic [CNT_W-1:0] r_err;
  logic [PW-1:0]    w_exact;

  assign w_exact = {{WIDTH{1'b0}}, r_a2} * {{WIDTH{1'b0}}, r_b2};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a2    <= '0;
      r_b2    <= '0;
      r_inex3 <= 1'b0;
      r_err   <= '0;
    end else begin
      if (w_adv1) begin
        r_a2 <= r_a1;
        r_b2 <= r_b1;
      end
      if (w_adv2) r_inex3 <= (w_sum != w_exact);
      if (err_clr) begin
        r_err <= '0;
      end else if (r_v3 && out_rdy && r_inex3 && (r_err != {CNT_W{1'b1}})) begin
        r_err <= r_err + 1'b1;
      end
    end
  end

  assign err_cnt = r_err;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ercm_mult_pipe.sv
`default_nettype none
// ============================================================================
// tb_ercm_mult_pipe - randomized scoreboard bench with a column-sum model.
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_ercm_mult_pipe;
  import ercm_pkg::*;

  localparam int W    = ERCM_WIDTH;
  localparam int PW   = 2*W;
  localparam int KW   = ERCM_KW;
  localparam int KRST = 4;
`ifdef ERCM_ERR_STAT_EN
  localparam int CW   = 2;
`endif

  typedef struct {
    int prod;
    int exact;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_vld = 1'b0, out_rdy = 1'b0, cfg_we = 1'b0;
  logic          in_rdy, out_vld;
  logic [W-1:0]  a = '0, b = '0;
  ercm_prod_t    dat_o;
  ercm_k_t       cfg_k = '0, k_o;
`ifdef ERCM_ERR_STAT_EN
  logic          err_clr = 1'b0;
  logic [CW-1:0] err_cnt;
`endif

  int            n_chk = 0, n_fail = 0;
  int            k_ref = KRST;
  int            err_ref = 0;
  exp_t          sb[$];
  ercm_prod_t    got[$];
  logic          stall_prev = 1'b0;
  ercm_prod_t    dat_prev = '0;

  always #5 clk = ~clk;

  ercm_mult_pipe #(
    .WIDTH (W),
    .K_RST (KRST)
`ifdef ERCM_ERR_STAT_EN
    , .CNT_W (CW)
`endif
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_vld   (in_vld),
    .in_rdy   (in_rdy),
    .dat_in_a (a),
    .dat_in_b (b),
    .out_vld  (out_vld),
    .out_rdy  (out_rdy),
    .dat_o    (dat_o),
    .cfg_we   (cfg_we),
    .cfg_k    (cfg_k),
    .k_o      (k_o)
`ifdef ERCM_ERR_STAT_EN
    , .err_clr (err_clr)
    , .err_cnt (err_cnt)
`endif
  );

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Column model: count ones per column, OR below K, exact weighted sum above.
  function automatic int ref_mult(input int av, input int bv, input int kv);
    int res;
    int n;
    res = 0;
    for (int c = 0; c < PW; c++) begin
      n = 0;
      for (int i = 0; i < W; i++) begin
        if (c - i >= 0 && c - i < W) n += ((av >> i) & 1) * ((bv >> (c - i)) & 1);
      end
      if (c < kv) res += (n > 0) ? (1 << c) : 0;
      else        res += n << c;
    end
    return res;
  endfunction

  always @(negedge clk) begin : mon
    exp_t e;
    bit   del_inexact;
    del_inexact = 1'b0;
    if (rst) begin
      sb.delete();
      k_ref = KRST;
      err_ref = 0;
      stall_prev = 1'b0;
    end else begin
      check_eq("k_o", k_o, k_ref);
      check_eq("in_rdy", in_rdy, (sb.size() < 3) || out_rdy);
      if (stall_prev) begin
        check_eq("hold_vld", out_vld, 1);
        check_eq("hold_dat", dat_o, dat_prev);
      end
`ifdef ERCM_ERR_STAT_EN
      check_eq("err_cnt", err_cnt, err_ref);
`endif
      if (out_vld) check_eq("vld_has_data", sb.size() > 0, 1);
      if (out_vld && out_rdy && sb.size() > 0) begin
        e = sb.pop_front();
        check_eq("dat_o", dat_o, e.prod);
        got.push_back(dat_o);
        del_inexact = (e.prod != e.exact);
      end
`ifdef ERCM_ERR_STAT_EN
      if (err_clr) err_ref = 0;
      else if (del_inexact && err_ref < (1 << CW) - 1) err_ref++;
`endif
      if (in_vld && in_rdy) begin
        e.prod  = ref_mult(a, b, k_ref);
        e.exact = int'(a) * int'(b);
        sb.push_back(e);
      end
      if (cfg_we) k_ref = (cfg_k > PW) ? PW : cfg_k;
      stall_prev = out_vld && !out_rdy;
      dat_prev   = dat_o;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_k(input int kv);
    tick();
    cfg_we = 1'b1;
    cfg_k  = KW'(kv);
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic drain();
    tick();
    in_vld = 1'b0;
    cfg_we = 1'b0;
    out_rdy = 1'b1;
    repeat (8) tick();
    check_eq("drain_empty", sb.size(), 0);
  endtask

  // Single op into an empty pipe; checks latency and the product.
  task automatic send_and_wait(input int av, input int bv, input int expv, input string tag);
    int lat;
    tick();
    a = W'(av);
    b = W'(bv);
    in_vld = 1'b1;
    out_rdy = 1'b1;
    @(negedge clk);
    check_eq({tag, "_rdy"}, in_rdy, 1);
    tick();
    in_vld = 1'b0;
    lat = 0;
    for (int n = 1; n <= 12 && lat == 0; n++) begin
      @(negedge clk);
      if (out_vld) begin
        lat = n;
        check_eq({tag, "_dat"}, dat_o, expv);
      end else begin
        tick();
      end
    end
    check_eq({tag, "_lat"}, lat, 3);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    int next;
    int model8;
    rst = 1'b1;
    out_rdy = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_out_vld", out_vld, 0);
    check_eq("rst_dat_o", dat_o, 0);
    check_eq("rst_k_o", k_o, KRST);
    check_eq("rst_in_rdy", in_rdy, 1);

    set_k(0);
    send_and_wait(255, 255, 65025, "exact_ff");
    set_k(4);
    send_and_wait(255, 255, 64991, "k4_ff");
    set_k(2);
    send_and_wait(3, 3, 7, "k2_33");
    drain();

    for (int k = 0; k <= PW; k++) begin
      set_k(k);
      for (int t = 0; t < 25; t++) begin
        tick();
        in_vld  = ($urandom_range(0, 3) != 0);
        a       = W'($urandom);
        b       = W'($urandom);
        out_rdy = ($urandom_range(0, 3) != 0);
        cfg_we  = ($urandom_range(0, 15) == 0);
        cfg_k   = KW'($urandom_range(0, 31));
      end
    end
    drain();

    // Backpressure: only three ops fit, the rest wait until release.
    tick();
    out_rdy = 1'b0;
    next = 0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      in_vld = (next < 5);
      a = W'(10 + next);
      b = W'(20 + next);
      @(negedge clk);
      if (in_vld && in_rdy) next++;
      tick();
    end
    check_eq("bp_accepted", next, 3);
    @(negedge clk);
    check_eq("bp_in_rdy", in_rdy, 0);
    tick();
    out_rdy = 1'b1;
    for (int cyc = 0; cyc < 20 && next < 5; cyc++) begin
      in_vld = 1'b1;
      a = W'(10 + next);
      b = W'(20 + next);
      @(negedge clk);
      if (in_rdy) next++;
      tick();
    end
    check_eq("bp_all_accepted", next, 5);
    drain();

    // K change mid-stream: the op in the write cycle still uses the old K.
    set_k(0);
    got.delete();
    for (int i = 0; i < 8; i++) begin
      tick();
      in_vld = 1'b1;
      a = 8'hFF;
      b = 8'hFF;
      cfg_we = (i == 3);
      cfg_k = KW'(8);
    end
    drain();
    model8 = ref_mult(255, 255, 8);
    check_eq("stream_count", got.size(), 8);
    for (int i = 0; i < 8 && i < got.size(); i++) begin
      check_eq($sformatf("stream_%0d", i), got[i], (i <= 3) ? 65025 : model8);
    end
    set_k(20);
    @(negedge clk);
    check_eq("k_sat", k_o, PW);

    // Reset with three ops in flight.
    set_k(8);
    tick();
    out_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_vld = 1'b1;
      a = W'(100 + i);
      b = W'(7);
      tick();
    end
    in_vld = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_vld", out_vld, 0);
    check_eq("mid_rst_k", k_o, KRST);
    tick();
    out_rdy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_eq("no_stale", out_vld, 0);
      tick();
    end

`ifdef ERCM_ERR_STAT_EN
    set_k(2);
    tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    for (int i = 0; i < 3; i++) send_and_wait(3, 3, 7, "err_op");
    tick();
    @(negedge clk);
    check_eq("err_three", err_cnt, 3);
    send_and_wait(3, 3, 7, "err_sat_op");
    tick();
    @(negedge clk);
    check_eq("err_saturate", err_cnt, 3);
    tick();
    out_rdy = 1'b0;
    a = 8'd3;
    b = 8'd3;
    in_vld = 1'b1;
    tick();
    in_vld = 1'b0;
    next = 0;
    for (int n = 0; n < 10 && next == 0; n++) begin
      @(negedge clk);
      if (out_vld) next = 1;
      else tick();
    end
    check_eq("err_held_vld", next, 1);
    tick();
    out_rdy = 1'b1;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    @(negedge clk);
    check_eq("err_clr_win", err_cnt, 0);
`endif

    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
